run_det_sched: RTL and testbench

- Round-robin scheduler that shares one serial run-of-ones detector among NREQ requesters.
- A granted requester's WIDTH-bit frame is captured, then shifted LSB-first into the detector, one bit per cycle.
- Per frame, the block counts bit positions that complete a run of at least RUN consecutive ones inside the frame, then reports the count with the requester id.
- Sits between frame producers and the shared detector datapath; it is the detector's only driver.

---
 rtl/run_det_pkg.sv | 22 ++
 rtl/run_det.sv | 31 +++
 rtl/run_det_sched.sv | 144 ++++++++++++++
 tb/tb_run_det_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_det_pkg.sv
// Shared types and helpers for the run-of-ones detector scheduler.
package run_det_pkg;

    typedef enum logic [1:0] {StIdle, StShift, StDrain, StDone} state_t;

    localparam int unsigned MaxReq = 32;

    // Never returns less than 1 so that a derived width is always a legal vector.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic logic [MaxReq-1:0] onehot(input int unsigned idx);
        return MaxReq'(1) << idx;
    endfunction

endpackage

// File: rtl/run_det.sv
// Serial run-of-ones detector: y_out is high while the last RUN inputs were all ones.
module run_det
    import run_det_pkg::*;
#(
    parameter int unsigned RUN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic x_in,
    output logic y_out
);

    localparam int unsigned CW = clog2(RUN + 1);

    logic [CW-1:0] r_cnt;

    // Saturates at RUN so a long run keeps flagging on every further one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || !x_in) begin
            r_cnt <= '0;
        end else if (r_cnt != CW'(RUN)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign y_out = (r_cnt == CW'(RUN));

endmodule

// File: rtl/run_det_sched.sv
// Round-robin scheduler feeding one requester's frame at a time through a shared
// run-of-ones detector and reporting the per-frame hit count.
module run_det_sched
    import run_det_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RUN   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*WIDTH-1:0]         frame_data,
    output logic [NREQ-1:0]               gnt,
    output logic                          busy,
    output logic                          done,
    output logic [clog2(NREQ)-1:0]        done_id,
    output logic                          hit,
    output logic [clog2(WIDTH+1)-1:0]     hit_cnt
);

    localparam int unsigned IDW = clog2(NREQ);
    localparam int unsigned CW  = clog2(WIDTH + 1);

    // First set request at or after p, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDW-1:0]  p);
        logic [IDW-1:0] pick;
        logic [IDW-1:0] idx;
        pick = p;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx = IDW'((32'(p) + 32'(i)) % NREQ);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
    logic            r_done;
    logic            r_hit;
    logic [IDW-1:0]  r_done_id;
    logic [IDW-1:0]  r_sel;
    logic [IDW-1:0]  r_ptr;
    logic [CW-1:0]   r_hit_cnt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_bitcnt;
    logic [WIDTH-1:0] r_shreg;

    logic            w_start;
    logic            w_x;
    logic            w_y;
    logic [IDW-1:0]  w_sel;
    logic [WIDTH-1:0] w_slice;

    assign w_sel   = rr_pick(req, r_ptr);
    assign w_start = (r_state == StIdle) && (req != '0);
    assign w_slice = frame_data[32'(w_sel) * WIDTH +: WIDTH];
    assign w_x     = (r_state == StShift) && r_shreg[0];

    run_det #(
        .RUN (RUN)
    ) u_run_det (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_start),
        .x_in  (w_x),
        .y_out (w_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hit     <= 1'b0;
            r_done_id <= '0;
            r_hit_cnt <= '0;
            r_sel     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_shreg   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done    <= 1'b0;
                    r_hit     <= 1'b0;
                    r_done_id <= '0;
                    r_hit_cnt <= '0;
                    if (w_start) begin
                        r_gnt    <= NREQ'(onehot(32'(w_sel)));
                        r_busy   <= 1'b1;
                        r_sel    <= w_sel;
                        r_shreg  <= w_slice;
                        r_bitcnt <= '0;
                        r_cnt    <= '0;
                        r_state  <= StShift;
                    end
                end
                StShift: begin
                    r_shreg  <= r_shreg >> 1;
                    r_bitcnt <= r_bitcnt + CW'(1);
                    // The detector lags one bit; its output in the first cycle is stale.
                    if (w_y && (r_bitcnt != '0)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (r_bitcnt == CW'(WIDTH - 1)) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (w_y) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    r_state <= StDone;
                end
                StDone: begin
                    r_done    <= 1'b1;
                    r_done_id <= r_sel;
                    r_hit_cnt <= r_cnt;
                    r_hit     <= (r_cnt != '0);
                    r_gnt     <= '0;
                    r_busy    <= 1'b0;
                    r_ptr     <= (r_sel == IDW'(NREQ - 1)) ? '0 : r_sel + IDW'(1);
                    r_state   <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign hit     = r_hit;
    assign hit_cnt = r_hit_cnt;

endmodule

// File: tb/tb_run_det_sched.sv
// Bench for run_det_sched: timeline-level reference model plus directed frames.
module tb_run_det_sched;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned RUN   = 3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] frame_data = '0;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [1:0]            done_id;
    logic                  hit;
    logic [3:0]            hit_cnt;

    run_det_sched #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .RUN   (RUN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .frame_data (frame_data),
        .gnt        (gnt),
        .busy       (busy),
        .done       (done),
        .done_id    (done_id),
        .hit        (hit),
        .hit_cnt    (hit_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Count positions i where bits i-RUN+1..i all exist and are all ones.
    function automatic int hits(input logic [WIDTH-1:0] f);
        int n;
        bit all1;
        n = 0;
        for (int i = RUN - 1; i < WIDTH; i++) begin
            all1 = 1'b1;
            for (int j = i - RUN + 1; j <= i; j++) if (!f[j]) all1 = 1'b0;
            if (all1) n++;
        end
        return n;
    endfunction

    // Reference model: a frame occupies WIDTH+2 grant cycles, then one done cycle.
    bit              m_busy = 1'b0;
    int              m_t    = 0;
    int              m_sel  = 0;
    int              m_ptr  = 0;
    logic [WIDTH-1:0] m_frame = '0;
    logic [NREQ-1:0] e_gnt  = '0;
    bit              e_busy = 1'b0;
    bit              e_done = 1'b0;
    int              e_id   = 0;
    int              e_cnt  = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 1'b0;
                m_ptr  = 0;
                m_t    = 0;
                e_done = 1'b0;
            end else begin
                e_done = 1'b0;
                if (m_busy) begin
                    m_t++;
                    if (m_t == WIDTH + 2) begin
                        m_busy = 1'b0;
                        e_done = 1'b1;
                        e_id   = m_sel;
                        e_cnt  = hits(m_frame);
                        m_ptr  = (m_sel + 1) % NREQ;
                    end
                end else if (req != '0) begin
                    for (int k = NREQ - 1; k >= 0; k--) begin
                        if (req[(m_ptr + k) % NREQ]) m_sel = (m_ptr + k) % NREQ;
                    end
                    m_frame = frame_data[m_sel*WIDTH +: WIDTH];
                    m_busy  = 1'b1;
                    m_t     = 0;
                end
            end
            e_gnt  = m_busy ? NREQ'(1 << m_sel) : '0;
            e_busy = m_busy;
        end
    end

    int n_done     = 0;
    int cyc        = 0;
    int g0_cycles  = 0;
    int q_id[$];
    int q_cnt[$];
    int q_hit[$];
    int q_cyc[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check("gnt", 32'(gnt), 32'(e_gnt));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            if (e_done) begin
                check("done_id", 32'(done_id), 32'(e_id));
                check("hit_cnt", 32'(hit_cnt), 32'(e_cnt));
                check("hit", 32'(hit), 32'(e_cnt != 0));
            end
            if (gnt[0]) g0_cycles++;
            if (done) begin
                n_done++;
                q_id.push_back(int'(done_id));
                q_cnt.push_back(int'(hit_cnt));
                q_hit.push_back(int'(hit));
                q_cyc.push_back(cyc);
            end
        end
    end

    task automatic set_frame(input int idx, input logic [WIDTH-1:0] val);
        frame_data[idx*WIDTH +: WIDTH] = val;
    endtask

    task automatic wait_done(input string name);
        int start;
        start = n_done;
        for (int i = 0; i < 40 && n_done == start; i++) begin
            @(negedge clk);
            #1;
        end
        if (n_done == start) check({name, "_timeout"}, 32'(0), 32'(1));
    endtask

    // Pulse req for the grant edge only, then wait for the result.
    task automatic one_frame(input string name, input logic [NREQ-1:0] r);
        @(posedge clk);
        #1;
        req = r;
        @(posedge clk);
        #1;
        req = '0;
        wait_done(name);
    endtask

    initial begin
        int base;
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_hit_cnt", 32'(hit_cnt), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single frame, req dropped right after the grant.
        g0_cycles = 0;
        set_frame(0, 8'h07);
        one_frame("t1", 4'b0001);
        check("t1_id", 32'(q_id[$]), 32'(0));
        check("t1_cnt", 32'(q_cnt[$]), 32'(1));
        check("t1_hit", 32'(q_hit[$]), 32'(1));
        check("t1_gnt_cycles", 32'(g0_cycles), 32'(10));

        set_frame(1, 8'hFF);
        one_frame("t2", 4'b0010);
        check("t2_id", 32'(q_id[$]), 32'(1));
        check("t2_cnt", 32'(q_cnt[$]), 32'(6));
        check("t2_hit", 32'(q_hit[$]), 32'(1));

        set_frame(1, 8'h6D);
        one_frame("t3", 4'b0010);
        check("t3_cnt", 32'(q_cnt[$]), 32'(0));
        check("t3_hit", 32'(q_hit[$]), 32'(0));

        // Trailing ones of one frame must not combine with the next frame.
        set_frame(0, 8'hC0);
        one_frame("iso_a", 4'b0001);
        check("iso_a_cnt", 32'(q_cnt[$]), 32'(0));
        set_frame(1, 8'h01);
        one_frame("iso_b", 4'b0010);
        check("iso_b_id", 32'(q_id[$]), 32'(1));
        check("iso_b_cnt", 32'(q_cnt[$]), 32'(0));

        // Reset in the fourth shift cycle aborts the frame silently.
        set_frame(0, 8'hFF);
        @(posedge clk);
        #1;
        req = 4'b0001;
        @(posedge clk);
        #1;
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        base = n_done;
        @(negedge clk);
        #1;
        check("abort_gnt", 32'(gnt), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        check("abort_no_done", 32'(n_done), 32'(base));

        set_frame(2, 8'h1C);
        @(posedge clk);
        #1;
        req = 4'b0100;
        @(posedge clk);
        #1;
        req = '0;
        @(negedge clk);
        #1;
        check("post_rst_gnt", 32'(gnt), 32'(4'b0100));
        wait_done("post_rst");
        check("post_rst_id", 32'(q_id[$]), 32'(2));
        check("post_rst_cnt", 32'(q_cnt[$]), 32'(1));

        // Pointer back to 0 after reset; all requesters held continuously.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_frame(0, 8'h07);
        set_frame(1, 8'hFF);
        set_frame(2, 8'h0E);
        set_frame(3, 8'hF0);
        base = q_id.size();
        req  = 4'b1111;
        for (int k = 0; k < 5; k++) wait_done("rr");
        req = '0;
        if (q_id.size() >= base + 5) begin
            for (int k = 0; k < 5; k++) begin
                check("rr_order", 32'(q_id[base+k]), 32'(k % 4));
            end
            check("rr_cnt0", 32'(q_cnt[base]), 32'(1));
            check("rr_cnt1", 32'(q_cnt[base+1]), 32'(6));
            check("rr_cnt2", 32'(q_cnt[base+2]), 32'(1));
            check("rr_cnt3", 32'(q_cnt[base+3]), 32'(2));
            for (int k = 1; k < 5; k++) begin
                check("rr_period", 32'(q_cyc[base+k] - q_cyc[base+k-1]), 32'(11));
            end
        end else begin
            check("rr_done_count", 32'(q_id.size() - base), 32'(5));
        end

        repeat (4) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
